ram_to_ethernet: RTL



---
 rtl/ram_to_ethernet_pkg.sv | 20 ++
 rtl/ram_to_ethernet_word_serializer.sv | 36 +++
 rtl/ram_to_ethernet.sv | 95 +++++++++
 3 files changed

// File: rtl/ram_to_ethernet_pkg.sv
// ram_to_ethernet_pkg: word geometry, FSM encoding and debug layout shared by the screen-packet paths
package ram_to_ethernet_pkg;
  localparam int WORD_BYTES = 96;
  localparam int DATA_W = 8 * WORD_BYTES;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND   = 3'd2,
    FINISH = 3'd3
  } state_t;
  typedef struct packed {
    logic [2:0] state;
    logic       prefetch_full;
    logic       outstanding;
    logic [2:0] reserved;
  } debug_t;
  function automatic debug_t pack_debug(state_t s, logic pf, logic os);
    return '{state: s, prefetch_full: pf, outstanding: os, reserved: 3'b000};
  endfunction
endpackage

// File: rtl/ram_to_ethernet_word_serializer.sv
// ram_to_ethernet_word_serializer: shifts one RAM word out byte 0 first through a valid/ready stage
module ram_to_ethernet_word_serializer #(
  parameter int WORD_BYTES = ram_to_ethernet_pkg::WORD_BYTES
) (
  input  logic                    clk125,
  input  logic                    reset,
  input  logic                    load,
  input  logic [8*WORD_BYTES-1:0] word,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    last
);
  localparam int CNT_W = $clog2(WORD_BYTES);
  logic [8*WORD_BYTES-1:0] shift_reg;
  logic [CNT_W-1:0]        byte_cnt;
  logic                    fire;
  assign fire = tx_valid && tx_ready;
  assign last = fire && byte_cnt == CNT_W'(WORD_BYTES - 1);
  assign tx_data = shift_reg[7:0];
  // a load wins over the final shift so consecutive words abut; otherwise advance one byte per handshake
  always_ff @(posedge clk125 or negedge reset)
    if (!reset) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shift_reg <= word;
      byte_cnt  <= '0;
      tx_valid  <= 1'b1;
    end else if (fire) begin
      shift_reg <= shift_reg >> 8;
      byte_cnt  <= last ? '0 : byte_cnt + 1'b1;
      tx_valid  <= !last;
    end
endmodule

// File: rtl/ram_to_ethernet.sv
// ram_to_ethernet: fetches a run of RAM words and streams them bytewise to the MAC with one-word prefetch
module ram_to_ethernet #(
  parameter int WORD_BYTES = ram_to_ethernet_pkg::WORD_BYTES,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16
) (
  input  logic                    clk125,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_address,
  input  logic [LEN_W-1:0]        word_count,
  output logic                    read_ram,
  output logic [ADDR_W-1:0]       read_address,
  input  logic                    read_valid,
  input  logic [8*WORD_BYTES-1:0] read_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              debug
);
  import ram_to_ethernet_pkg::*;
  state_t                  state, next_state;
  logic [LEN_W-1:0]        req_left;
  logic                    outstanding, pf_full, accept, last, launch;
  logic                    ser_load, pf_capture, pf_take;
  logic [8*WORD_BYTES-1:0] pf_data, ser_word;
  assign accept = read_valid && outstanding;
  assign launch = start && (state == IDLE || state == FINISH);
  assign debug = pack_debug(state, pf_full, outstanding);
  ram_to_ethernet_word_serializer #(.WORD_BYTES(WORD_BYTES)) u_ser (
    .clk125  (clk125),
    .reset   (reset),
    .load    (ser_load),
    .word    (ser_word),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .last    (last)
  );
  // state register
  always_ff @(posedge clk125 or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next_state;
  // next state, read issue and routing of returned words to the serializer or the prefetch buffer
  always_comb begin
    next_state = state;
    read_ram   = 1'b0;
    ser_load   = 1'b0;
    ser_word   = read_data;
    pf_capture = 1'b0;
    pf_take    = 1'b0;
    busy       = state == FETCH || state == SEND;
    done       = state == FINISH;
    if (launch) next_state = word_count != '0 ? FETCH : FINISH;
    else if (state == FINISH) next_state = IDLE;
    else if (state == FETCH) begin
      read_ram = !outstanding && req_left != '0;
      if (accept) begin
        ser_load   = 1'b1;
        next_state = SEND;
      end
    end else if (state == SEND) begin
      read_ram = !pf_full && !outstanding && req_left != '0;
      if (!last) pf_capture = accept;
      else if (pf_full) begin
        ser_load = 1'b1;
        ser_word = pf_data;
        pf_take  = 1'b1;
      end else if (accept) ser_load = 1'b1;
      else next_state = outstanding || req_left != '0 ? FETCH : FINISH;
    end
  end
  // request address/count bookkeeping, single outstanding read and the prefetch buffer
  always_ff @(posedge clk125 or negedge reset)
    if (!reset) begin
      read_address <= '0;
      req_left     <= '0;
      outstanding  <= 1'b0;
      pf_full      <= 1'b0;
      pf_data      <= '0;
    end else begin
      if (launch) begin
        read_address <= base_address;
        req_left     <= word_count;
      end else if (read_ram) begin
        read_address <= read_address + 1'b1;
        req_left     <= req_left - 1'b1;
      end
      outstanding <= read_ram || (outstanding && !read_valid);
      pf_full     <= pf_capture || (pf_full && !pf_take);
      if (pf_capture) pf_data <= read_data;
    end
endmodule
